pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor; multi-bit, clocked successor of the 1-bit full adder.
//  WIDTH-bit operands split into STAGES equal chunks; one chunk per stage, carry registered between stages.
//  Streaming valid/ready on both sides; one transaction per cycle when unstalled. Used as the ALU add path.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0 required (elaboration error otherwise)
//  STAGES  4   pipeline depth = latency in cycles; 1 <= STAGES <= WIDTH; chunk width CW = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      a, b, carryin, sub valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carryin    in   1      carry into bit 0 (ignored when sub=1)
//  sub        in   1      1: a - b; 0: a + b + carryin
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  carryout   out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  zero       out  1      [ADDER_FLAGS_EN only] sum == 0
//  overflow   out  1      [ADDER_FLAGS_EN only] signed overflow
// BEHAVIOUR
//  - Effective B = sub ? ~b : b; effective cin = sub ? 1 : carryin. {carryout,sum} = a + effB + cin, WIDTH+1 bits exact.
//  - Stage k (0..STAGES-1) adds chunk k [k*CW +: CW] of a/effB with carry from stage k-1 register (stage 0: cin).
//  - Upper operand chunks skew forward with the transaction; finished lower sum chunks ride forward likewise.
//  - Global stall: advance = !out_valid || out_ready. in_ready = advance (combinational). All stages move together.
//  - Accept on in_valid && in_ready. Unstalled latency = STAGES cycles from accept edge to out_valid high.
//  - Bubbles propagate as invalid stages; no reordering, no drops, no duplicates; throughput 1/cycle.
//  - out_valid && !out_ready: sum/carryout/flags and every stage hold unchanged; in_ready=0.
//  - in_valid with in_ready=0: inputs ignored, not captured; upstream must hold.
//  - Simultaneous out handshake and in accept in same cycle: both occur, pipeline stays full.
//  - Reset: all stage valids, out_valid, sum, carryout, zero, overflow = 0; in_ready = 1 the cycle after reset.
//  - Reset mid-operation: all in-flight transactions discarded; no output produced for them.
//  - Wrap-around: sum modulo 2^WIDTH, excess in carryout; no saturation.
//  - STAGES=1: single registered adder, latency 1.
// CONFIGURATION
//  ADDER_FLAGS_EN defined: zero and overflow ports exist, registered with sum, same latency/stall rules.
//   overflow = (a[W-1] == effB[W-1]) && (sum[W-1] != a[W-1]).
//  ADDER_FLAGS_EN undefined: zero/overflow ports and logic absent; all else identical.
// TESTING (WIDTH=8, STAGES=2 unless noted; out_ready=1 unless noted)
//  1 reset held 2 cycles mid-stream -> out_valid=0, sum=0x00, carryout=0; in-flight lost; in_ready=1 next cycle.
//  2 a=0x3C b=0x47 sub=0 cin=1 -> 2 cycles later out_valid=1 sum=0x84 carryout=0 overflow=1 zero=0.
//  3 a=0xFF b=0x01 sub=0 cin=0 -> sum=0x00 carryout=1 zero=1 overflow=0 (wrap-around, carry across chunk boundary).
//  4 a=0x10 b=0x20 sub=1 -> sum=0xF0 carryout=0 (borrow); a=0x80 b=0x01 sub=1 -> sum=0x7F carryout=1 overflow=1.
//  5 back-to-back 4 transactions, out_ready low 3 cycles mid-stream -> in_ready low while stalled, outputs held,
//    all 4 results in order, none dropped/duplicated.
//  6 WIDTH=32 STAGES=4: 1000 random a/b/sub/cin, random in_valid/out_ready -> every result equals reference model,
//    latency exactly 4 when unstalled; repeat STAGES=1 with latency 1.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked ripple add/sub, one chunk per stage, global stall.
// Optional zero/overflow flag outputs are enabled by defining ADDER_FLAGS_EN.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must split evenly into STAGES");
  end

  logic [WIDTH-1:0] w_effb;
  logic             w_cin;
  logic             w_adv;

  logic [WIDTH-1:0] w_ai [STAGES];
  logic [WIDTH-1:0] w_bi [STAGES];
  logic [WIDTH-1:0] w_si [STAGES];
  logic [WIDTH-1:0] w_sn [STAGES];
  logic [CW-1:0]    w_sc [STAGES];
  logic [STAGES-1:0] w_ci;
  logic [STAGES-1:0] w_vi;
  logic [STAGES-1:0] w_co;

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  assign w_effb = sub ? ~b : b;
  assign w_cin  = sub ? 1'b1 : carryin;

  // Whole pipe moves as one; only a held result blocks it.
  assign w_adv    = !r_v[L] || out_ready;
  assign in_ready = w_adv;

  assign out_valid = r_v[L];
  assign sum       = r_s[L];
  assign carryout  = r_c[L];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign w_ai[k] = a;
      assign w_bi[k] = w_effb;
      assign w_ci[k] = w_cin;
      assign w_vi[k] = in_valid;
      assign w_si[k] = '0;
    end else begin : g_body
      assign w_ai[k] = r_a[k-1];
      assign w_bi[k] = r_b[k-1];
      assign w_ci[k] = r_c[k-1];
      assign w_vi[k] = r_v[k-1];
      assign w_si[k] = r_s[k-1];
    end
    assign {w_co[k], w_sc[k]} =
      {1'b0, w_ai[k][k*CW +: CW]} +
      {1'b0, w_bi[k][k*CW +: CW]} +
      {{CW{1'b0}}, w_ci[k]};
  end

  // Merge each stage's fresh chunk into the partial sum riding with it.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_sn[k] = w_si[k];
      w_sn[k][k*CW +: CW] = w_sc[k];
    end
  end

  // Stage registers: valids always shift, payload only with a valid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_s[k] <= '0;
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_vi[k];
        if (w_vi[k]) begin
          r_a[k] <= w_ai[k];
          r_b[k] <= w_bi[k];
          r_c[k] <= w_co[k];
          r_s[k] <= w_sn[k];
        end
      end
    end
  end

`ifdef ADDER_FLAGS_EN
  logic w_zn;
  logic w_ovn;
  logic r_zero;
  logic r_ovf;

  assign w_zn  = (w_sn[L] == '0);
  assign w_ovn = (w_ai[L][WIDTH-1] == w_bi[L][WIDTH-1]) &&
                 (w_sn[L][WIDTH-1] != w_ai[L][WIDTH-1]);

  assign zero     = r_zero;
  assign overflow = r_ovf;

  // Flags are captured alongside the final sum chunk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv && w_vi[L]) begin
      r_zero <= w_zn;
      r_ovf  <= w_ovn;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed 8-bit vectors, stall/reset sequences,
// and randomized 32-bit runs against an arithmetic reference model.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // 8-bit, 2-stage instance
  logic       s8_iv, s8_ir, s8_ov, s8_or, s8_cin, s8_sub, s8_co;
  logic [7:0] s8_a, s8_b, s8_s;
  logic       s8_z, s8_v;

  // shared 32-bit drive for the 4-stage and 1-stage instances
  logic        sel;
  logic        d_iv, d_or, d_cin, d_sub;
  logic [31:0] d_a, d_b;
  logic        ir4, ov4, co4, ir1, ov1, co1;
  logic [31:0] s4, s1;
  logic        z4, v4, z1, v1;
  logic        o_ir, o_ov, o_co, o_z, o_v;
  logic [31:0] o_s;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .reset(reset), .in_valid(s8_iv), .in_ready(s8_ir),
    .a(s8_a), .b(s8_b), .carryin(s8_cin), .sub(s8_sub),
    .out_valid(s8_ov), .out_ready(s8_or), .sum(s8_s), .carryout(s8_co)
`ifdef ADDER_FLAGS_EN
    , .zero(s8_z), .overflow(s8_v)
`endif
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(d_iv & ~sel), .in_ready(ir4),
    .a(d_a), .b(d_b), .carryin(d_cin), .sub(d_sub),
    .out_valid(ov4), .out_ready(d_or), .sum(s4), .carryout(co4)
`ifdef ADDER_FLAGS_EN
    , .zero(z4), .overflow(v4)
`endif
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(d_iv & sel), .in_ready(ir1),
    .a(d_a), .b(d_b), .carryin(d_cin), .sub(d_sub),
    .out_valid(ov1), .out_ready(d_or), .sum(s1), .carryout(co1)
`ifdef ADDER_FLAGS_EN
    , .zero(z1), .overflow(v1)
`endif
  );

`ifndef ADDER_FLAGS_EN
  assign s8_z = 1'b0;
  assign s8_v = 1'b0;
  assign z4 = 1'b0;
  assign v4 = 1'b0;
  assign z1 = 1'b0;
  assign v1 = 1'b0;
`endif

  assign o_ir = sel ? ir1 : ir4;
  assign o_ov = sel ? ov1 : ov4;
  assign o_co = sel ? co1 : co4;
  assign o_s  = sel ? s1  : s4;
  assign o_z  = sel ? z1  : z4;
  assign o_v  = sel ? v1  : v4;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        z;
    logic        v;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  typedef struct {
    res_t r;
    int   acc;
  } pend_t;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  function automatic res_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic sb_op, logic cin);
    res_t   r;
    longint m, ua, ub, sa, sb, t, st, hi, lo;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
    hi = (m + 1) / 2 - 1;
    lo = -((m + 1) / 2);
    if (sb_op) begin
      t   = ua - ub;
      r.c = (ua >= ub);
      st  = sa - sb;
    end else begin
      t   = ua + ub + longint'(cin);
      r.c = ((t >> w) & 1) != 0;
      st  = sa + sb + longint'(cin);
    end
    r.s = 32'(t & m);
    r.z = ((t & m) == 0);
    r.v = (st > hi) || (st < lo);
    return r;
  endfunction

  task automatic run8(vec_t t, int idx);
    int lat;
    @(negedge clk);
    s8_a = t.a; s8_b = t.b; s8_sub = t.sub; s8_cin = t.cin; s8_iv = 1'b1;
    #1;
    chk($sformatf("v%0d in_ready", idx), 64'(s8_ir), 64'd1);
    @(negedge clk);
    s8_iv = 1'b0;
    lat = 1;
    while (!s8_ov && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'd2);
    chk($sformatf("v%0d sum", idx), 64'(s8_s), 64'(t.s));
    chk($sformatf("v%0d carryout", idx), 64'(s8_co), 64'(t.c));
`ifdef ADDER_FLAGS_EN
    chk($sformatf("v%0d zero", idx), 64'(s8_z), 64'(t.z));
    chk($sformatf("v%0d overflow", idx), 64'(s8_v), 64'(t.v));
`endif
  endtask

  task automatic rand_run(logic s, int n, bit bp);
    pend_t q[$];
    pend_t p;
    int    cyc, acc, done, lat_exp;
    bit    pending;
    cyc = 0; acc = 0; done = 0; pending = 0;
    lat_exp = s ? 1 : 4;
    @(negedge clk);
    d_iv = 1'b0;
    sel  = s;
    while (done < n && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      d_or = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!pending) begin
        if (acc < n && $urandom_range(0, 4) != 0) begin
          case ($urandom_range(0, 7))
            0: d_a = 32'h0;
            1: d_a = 32'hFFFF_FFFF;
            2: d_a = 32'h8000_0000;
            3: d_a = 32'h7FFF_FFFF;
            default: d_a = $urandom;
          endcase
          case ($urandom_range(0, 5))
            0: d_b = 32'h0;
            1: d_b = 32'hFFFF_FFFF;
            2: d_b = 32'h0000_0001;
            default: d_b = $urandom;
          endcase
          d_sub = 1'($urandom_range(0, 1));
          d_cin = 1'($urandom_range(0, 1));
          d_iv  = 1'b1;
        end else begin
          d_iv = 1'b0;
        end
      end
      #1;
      if (d_iv && o_ir) begin
        p.r = model(32, d_a, d_b, d_sub, d_cin);
        p.acc = cyc;
        q.push_back(p);
        acc++;
        pending = 0;
      end else begin
        pending = d_iv;
      end
      if (o_ov && d_or) begin
        if (q.size() == 0) begin
          chk($sformatf("r%0d spurious", s), 64'd1, 64'd0);
        end else begin
          p = q.pop_front();
          chk($sformatf("r%0d sum", s), 64'(o_s), 64'(p.r.s));
          chk($sformatf("r%0d carryout", s), 64'(o_co), 64'(p.r.c));
`ifdef ADDER_FLAGS_EN
          chk($sformatf("r%0d zero", s), 64'(o_z), 64'(p.r.z));
          chk($sformatf("r%0d overflow", s), 64'(o_v), 64'(p.r.v));
`endif
          if (!bp)
            chk($sformatf("r%0d latency", s), 64'(cyc - p.acc),
                64'(lat_exp));
        end
        done++;
      end
    end
    chk($sformatf("r%0d completed", s), 64'(done), 64'(n));
    @(negedge clk);
    d_iv = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    res_t exp4[4];
    logic [7:0] ia[4], ib[4];
    logic       isub[4];
    logic [8:0] got[$];
    logic [8:0] held;
    int  cyc, idx, ghost;
    bit  stall_prev;

    tbl[0] = '{8'h3C, 8'h47, 1'b0, 1'b1, 8'h84, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h55, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    s8_iv = 0; s8_or = 1; s8_a = 0; s8_b = 0; s8_cin = 0; s8_sub = 0;
    sel = 0; d_iv = 0; d_or = 1; d_a = 0; d_b = 0; d_cin = 0; d_sub = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset out_valid", 64'(s8_ov), 64'd0);
    chk("reset sum", 64'(s8_s), 64'd0);
    chk("reset carryout", 64'(s8_co), 64'd0);
    chk("reset in_ready", 64'(s8_ir), 64'd1);
    chk("reset out_valid32", 64'({ov4, ov1}), 64'd0);

    // reset in the middle of a stream discards everything in flight
    @(negedge clk);
    s8_a = 8'h12; s8_b = 8'h34; s8_sub = 0; s8_cin = 0; s8_iv = 1;
    @(negedge clk);
    s8_a = 8'h56; s8_b = 8'h01;
    @(negedge clk);
    s8_iv = 0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset out_valid", 64'(s8_ov), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset sum", 64'(s8_s), 64'd0);
    chk("midreset carryout", 64'(s8_co), 64'd0);
    chk("midreset in_ready", 64'(s8_ir), 64'd1);
    ghost = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (s8_ov) ghost++;
    end
    chk("midreset ghost outputs", 64'(ghost), 64'd0);

    for (int i = 0; i < 8; i++) run8(tbl[i], i);

    // back-to-back stream with a 3-cycle output stall
    ia = '{8'hF0, 8'h01, 8'h80, 8'h33};
    ib = '{8'h10, 8'hFF, 8'h7F, 8'h44};
    isub = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++)
      exp4[i] = model(8, 32'(ia[i]), 32'(ib[i]), isub[i], 1'b0);
    @(negedge clk);
    idx = 0; stall_prev = 0; held = '0;
    for (cyc = 1; cyc <= 16; cyc++) begin
      if (cyc > 1) @(negedge clk);
      s8_or = !(cyc >= 4 && cyc <= 6);
      if (idx < 4) begin
        s8_a = ia[idx]; s8_b = ib[idx]; s8_sub = isub[idx]; s8_cin = 0;
        s8_iv = 1;
      end else begin
        s8_iv = 0;
      end
      #1;
      if (s8_ov && !s8_or) begin
        chk($sformatf("stall in_ready c%0d", cyc), 64'(s8_ir), 64'd0);
        if (stall_prev)
          chk($sformatf("stall hold c%0d", cyc), 64'({s8_co, s8_s}),
              64'(held));
        stall_prev = 1;
        held = {s8_co, s8_s};
      end else begin
        stall_prev = 0;
      end
      if (s8_iv && s8_ir) idx++;
      if (s8_ov && s8_or) got.push_back({s8_co, s8_s});
    end
    s8_iv = 0;
    chk("stream count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size())
        chk($sformatf("stream item%0d", i), 64'(got[i]),
            64'({exp4[i].c, exp4[i].s[7:0]}));
    end

    rand_run(1'b0, 1000, 1'b1);
    rand_run(1'b0, 200, 1'b0);
    rand_run(1'b1, 1000, 1'b1);
    rand_run(1'b1, 200, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
